wb_select_queue: RTL and testbench

//  Parametrised writeback-data selector for the register-file write port.

---
 rtl/wb_select_queue.sv | 148 ++++++++++++++
 tb/tb_wb_select_queue.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_select_queue.sv
// ---------------------------------------------------------------------------
// wb_select_queue
//
// Writeback-data selector for the register-file write port. On each accepted
// request it picks one of NUM_SRC source buses or the constant CONST_VAL. It
// then queues the selected data, together with the destination register
// number, into a DEPTH-entry FIFO. This lets the control FSM keep issuing
// writebacks while the register-file port stalls.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous reset, active low
//   src_data   flattened sources, source k = [k*DATA_W +: DATA_W]
//   sel        source select (NUM_SRC selects CONST_VAL, above that is an error)
//   dest_in    destination register number (0 = $zero, data forced to 0)
//   in_valid   enqueue request
//   in_ready   queue can accept this cycle
//   out_data   head-entry data
//   out_dest   head-entry destination register
//   out_valid  head entry valid
//   out_ready  consumer takes the head this cycle
//   sel_err    sticky flag: an out-of-range sel was accepted
//   err_clr    synchronous clear of sel_err (wins over a same-cycle set)
//   out_par    even parity of the head data, 0 when empty
//
// Build option
//   WB_SELECT_PARITY_EN  when defined, each entry stores a parity bit that is
//                        computed at accept time. When undefined, out_par is
//                        tied to 0.
// ---------------------------------------------------------------------------
module wb_select_queue #(
  parameter int                DATA_W    = 32,
  parameter int                NUM_SRC   = 6,
  parameter int                SEL_W     = 3,
  parameter logic [DATA_W-1:0] CONST_VAL = DATA_W'(227),
  parameter int                DEPTH     = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  input  logic [SEL_W-1:0]          sel,
  input  logic [4:0]                dest_in,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [DATA_W-1:0]         out_data,
  output logic [4:0]                out_dest,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      sel_err,
  input  logic                      err_clr,
  output logic                      out_par
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] data_q [DEPTH];
  logic [4:0]        dest_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  // in_ready must read 0 while reset is held. count alone would already
  // report "not full" at that point, so this flag is needed as well.
  logic              run_q;

  logic              accept;
  logic              pop;
  logic              sel_bad;
  logic [DATA_W-1:0] sel_data;
  logic [DATA_W-1:0] wr_data;

  assign in_ready  = run_q && (count != CNT_W'(DEPTH));
  assign out_valid = (count != '0);
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign sel_bad   = (sel > SEL_W'(NUM_SRC));

  // Source mux. Out-of-range selects fall through to the zero default.
  // NOTE: every signal written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    sel_data = '0;
    if (sel == SEL_W'(NUM_SRC)) begin
      sel_data = CONST_VAL;
    end else begin
      for (int k = 0; k < NUM_SRC; k++) begin
        if (sel == SEL_W'(k)) sel_data = src_data[k*DATA_W +: DATA_W];
      end
    end
  end

  // Writes to $zero always carry zero data.
  assign wr_data = (dest_in == 5'd0) ? '0 : sel_data;

  // NOTE: queue storage is reset along with the control state, because the
  // head must read back as zero while reset is asserted. Sequential state
  // uses non-blocking assignments only, so every flop samples values from
  // before the edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run_q   <= 1'b0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      sel_err <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        dest_q[i] <= '0;
      end
    end else begin
      run_q <= 1'b1;
      if (accept) begin
        data_q[wr_ptr] <= wr_data;
        dest_q[wr_ptr] <= dest_in;
        wr_ptr         <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({accept, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (err_clr)               sel_err <= 1'b0;
      else if (accept && sel_bad) sel_err <= 1'b1;
    end
  end

  assign out_data = data_q[rd_ptr];
  assign out_dest = dest_q[rd_ptr];

`ifdef WB_SELECT_PARITY_EN
  logic par_q [DEPTH];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) par_q[i] <= 1'b0;
    end else if (accept) begin
      // Parity covers the data actually stored, so it always matches out_data.
      par_q[wr_ptr] <= ^wr_data;
    end
  end

  assign out_par = out_valid && par_q[rd_ptr];
`else
  assign out_par = 1'b0;
`endif

endmodule

// File: tb/tb_wb_select_queue.sv
module tb_wb_select_queue;

  localparam int DATA_W  = 32;
  localparam int NUM_SRC = 6;
  localparam int SEL_W   = 3;

`ifdef WB_SELECT_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  // Source buses: 0 ALU, 1 LS, 2..5 other datapath sources.
  localparam logic [NUM_SRC*DATA_W-1:0] SRC = {
    32'hDEAD_BEEF, 32'h0000_0003, 32'h0000_0007,
    32'hA5A5_0F0F, 32'hFFFF_FFFF, 32'h1234_5678
  };

  logic                      clk;
  logic                      reset;
  logic [NUM_SRC*DATA_W-1:0] src_data;
  logic [SEL_W-1:0]          sel;
  logic [4:0]                dest_in;
  logic                      in_valid;
  logic                      in_ready;
  logic [DATA_W-1:0]         out_data;
  logic [4:0]                out_dest;
  logic                      out_valid;
  logic                      out_ready;
  logic                      sel_err;
  logic                      err_clr;
  logic                      out_par;

  int checks = 0;
  int errors = 0;

  wb_select_queue dut (
    .clk      (clk),
    .reset    (reset),
    .src_data (src_data),
    .sel      (sel),
    .dest_in  (dest_in),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_dest (out_dest),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sel_err  (sel_err),
    .err_clr  (err_clr),
    .out_par  (out_par)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [SEL_W-1:0] sel;
    logic [4:0]       dest;
    logic [31:0]      exp_data;
    logic             exp_err;
    logic             exp_par;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Advance one cycle and settle just past the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] src_val(input int k);
    return SRC[k*DATA_W +: DATA_W];
  endfunction

  logic [31:0] exp_head;
  logic [4:0]  exp_dest;

  initial begin
    // Hand-computed expectations: {sel, dest, data, sel_err, parity}
    vecs[0] = '{3'd0,  5'd8, 32'h1234_5678, 1'b0, 1'b1};
    vecs[1] = '{3'd1,  5'd3, 32'hFFFF_FFFF, 1'b0, 1'b0};
    vecs[2] = '{3'd2, 5'd31, 32'hA5A5_0F0F, 1'b0, 1'b0};
    vecs[3] = '{3'd3,  5'd1, 32'h0000_0007, 1'b0, 1'b1};
    vecs[4] = '{3'd4,  5'd2, 32'h0000_0003, 1'b0, 1'b0};
    vecs[5] = '{3'd5,  5'd9, 32'hDEAD_BEEF, 1'b0, 1'b0};
    vecs[6] = '{3'd6,  5'd4, 32'd227,       1'b0, 1'b1};
    vecs[7] = '{3'd7,  5'd5, 32'h0000_0000, 1'b1, 1'b0};
    vecs[8] = '{3'd1,  5'd0, 32'h0000_0000, 1'b0, 1'b0};
    vecs[9] = '{3'd6,  5'd0, 32'h0000_0000, 1'b0, 1'b0};

    src_data  = SRC;
    reset     = 1'b0;
    sel       = '0;
    dest_in   = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    err_clr   = 1'b0;

    // Reset state, including in_ready held low while reset is asserted.
    #3;
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst out_data",  out_data,       32'd0);
    check("rst out_dest",  32'(out_dest),  32'd0);
    check("rst sel_err",   32'(sel_err),   32'd0);
    check("rst in_ready",  32'(in_ready),  32'd0);
    check("rst out_par",   32'(out_par),   32'd0);
    #9 reset = 1'b1;
    #1 check("in_ready before first edge", 32'(in_ready), 32'd0);
    step();
    check("in_ready after release", 32'(in_ready), 32'd1);

    // Table-driven single-entry vectors: push, inspect head, pop with err_clr.
    foreach (vecs[i]) begin
      sel      = vecs[i].sel;
      dest_in  = vecs[i].dest;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      check($sformatf("v%0d out_valid", i), 32'(out_valid), 32'd1);
      check($sformatf("v%0d out_data", i),  out_data,       vecs[i].exp_data);
      check($sformatf("v%0d out_dest", i),  32'(out_dest),  32'(vecs[i].dest));
      check($sformatf("v%0d sel_err", i),   32'(sel_err),   32'(vecs[i].exp_err));
      check($sformatf("v%0d out_par", i),   32'(out_par),   32'(PAR_EN & vecs[i].exp_par));
      out_ready = 1'b1;
      err_clr   = 1'b1;
      step();
      out_ready = 1'b0;
      err_clr   = 1'b0;
      check($sformatf("v%0d drained", i),   32'(out_valid), 32'd0);
      check($sformatf("v%0d err clr", i),   32'(sel_err),   32'd0);
      check($sformatf("v%0d par empty", i), 32'(out_par),   32'd0);
    end

    // sel_err is sticky, does not block the queue, and err_clr beats a new set.
    sel = 3'd7; dest_in = 5'd6; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    check("sel_err sticky", 32'(sel_err), 32'd1);
    check("err no block",   32'(in_ready), 32'd1);
    err_clr = 1'b1; in_valid = 1'b1;
    step();
    err_clr = 1'b0; in_valid = 1'b0;
    check("err_clr priority", 32'(sel_err), 32'd0);
    out_ready = 1'b1;
    step();
    step();
    out_ready = 1'b0;
    check("err entries drained", 32'(out_valid), 32'd0);

    // Fill to full with the consumer stalled; the third push must be refused.
    in_valid = 1'b1;
    sel = 3'd0; dest_in = 5'd8;
    step();
    check("fill1 in_ready", 32'(in_ready), 32'd1);
    sel = 3'd5; dest_in = 5'd9;
    step();
    check("fill2 in_ready", 32'(in_ready), 32'd0);
    sel = 3'd2; dest_in = 5'd10;
    step();
    in_valid = 1'b0;
    check("full head A",      out_data,      32'h1234_5678);
    check("full head A dest", 32'(out_dest), 32'd8);
    out_ready = 1'b1;
    step();
    check("pop head B",         out_data,      32'hDEAD_BEEF);
    check("pop head B dest",    32'(out_dest), 32'd9);
    check("in_ready after pop", 32'(in_ready), 32'd1);
    step();
    out_ready = 1'b0;
    check("C dropped", 32'(out_valid), 32'd0);

    // Steady push+pop at count 1 for ten cycles.
    sel = 3'd0; dest_in = 5'd1; in_valid = 1'b1;
    step();
    exp_head  = src_val(0);
    exp_dest  = 5'd1;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      sel     = SEL_W'((i + 1) % NUM_SRC);
      dest_in = 5'(i + 2);
      check($sformatf("stream%0d data", i), out_data,      exp_head);
      check($sformatf("stream%0d dest", i), 32'(out_dest), 32'(exp_dest));
      step();
      check($sformatf("stream%0d count1", i), 32'({out_valid, in_ready}), 32'd3);
      exp_head = src_val((i + 1) % NUM_SRC);
      exp_dest = 5'(i + 2);
    end
    in_valid = 1'b0;
    check("stream last data", out_data, exp_head);
    step();
    out_ready = 1'b0;
    check("stream drained", 32'(out_valid), 32'd0);

    // Asynchronous reset mid-stream with two entries queued.
    in_valid = 1'b1;
    sel = 3'd1; dest_in = 5'd3;
    step();
    sel = 3'd2; dest_in = 5'd4;
    step();
    in_valid = 1'b0;
    check("two queued", 32'(in_ready), 32'd0);
    #2 reset = 1'b0;
    #1;
    check("midrst out_valid", 32'(out_valid), 32'd0);
    check("midrst out_data",  out_data,       32'd0);
    check("midrst in_ready",  32'(in_ready),  32'd0);
    #1 reset = 1'b1;
    step();
    check("midrst release in_ready", 32'(in_ready),  32'd1);
    check("midrst stays empty",      32'(out_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
